// File: rtl/min_scan_scheduler_pkg.sv
// Shared types and defaults for the min-scan scheduler.
// State encoding plus index-width helper.
package min_sched_pkg;

    localparam int DEF_N = 3;
    localparam int DEF_W = 8;

    typedef enum logic [2:0] {
        START = 3'd0,
        CONV  = 3'd1,
        LOAD  = 3'd2,
        SCAN  = 3'd3,
        OUT   = 3'd4,
        ACK   = 3'd5
    } state_t;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/min_scan_scheduler_if.sv
// Converter and consumer handshake bundle for the min-scan scheduler.
// master = scheduler side, slave = converters/consumer side.
interface min_scan_scheduler_if
    import min_sched_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int W  = DEF_W,
    parameter int IW = idx_w(N)
);

    logic [N*W-1:0] x;
    logic [N-1:0]   eoc;
    logic           soc;
    logic [W-1:0]   min;
    logic [IW-1:0]  min_idx;
    logic           rfd;
    logic           dav_;
    logic           busy;

    modport master (
        input  x, eoc, rfd,
        output soc, min, min_idx, dav_, busy
    );

    modport slave (
        output x, eoc, rfd,
        input  soc, min, min_idx, dav_, busy
    );

endinterface

// File: rtl/min_scan_scheduler_cmp.sv
// Shared unsigned comparator: lt = a < b, sel = smaller of the two.
// One borrow subtractor provides both the flag and the selected value.
module min_cmp #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         lt,
    output logic [W-1:0] sel
);

    logic [W:0] diff;

    assign diff = {1'b0, a} - {1'b0, b};
    assign lt   = diff[W];
    // a == b + diff, so adding the difference back yields a
    assign sel  = b + (lt ? diff[W-1:0] : '0);

endmodule

// File: rtl/min_scan_scheduler.sv
// Round scheduler: start converters, bank results, scan for the
// minimum with one shared comparator, hand the result downstream.
module min_scan_scheduler
    import min_sched_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int W  = DEF_W,
    parameter int IW = idx_w(N)
) (
    input logic                  clock,
    input logic                  reset,
    min_scan_scheduler_if.master bus
);

    localparam logic [IW:0] LAST = (IW+1)'(N - 1);

    state_t        state;
    state_t        state_nx;
    logic          armed;
    logic [W-1:0]  bank [N];
    logic [W-1:0]  acc;
    logic [W-1:0]  min_q;
    logic [IW-1:0] aidx;
    logic [IW-1:0] idx_q;
    logic [IW:0]   cnt;
    logic [IW-1:0] cur;
    logic          lt;
    logic [W-1:0]  sel;

    assign cur = cnt[IW-1:0];

    min_cmp #(.W(W)) u_cmp (
        .a   (bank[cur]),
        .b   (acc),
        .lt  (lt),
        .sel (sel)
    );

    always_comb begin
        state_nx = state;
        case (state)
            START: if (armed && bus.eoc == '0) state_nx = CONV;
            CONV:  if (&bus.eoc)               state_nx = LOAD;
            LOAD:                              state_nx = SCAN;
            SCAN:  if (cnt == LAST)            state_nx = OUT;
            OUT:   if (!bus.rfd)               state_nx = ACK;
            ACK:   if (bus.rfd)                state_nx = START;
            default:                           state_nx = START;
        endcase
    end

    // armed holds soc low until the first edge after reset release
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= START;
            armed <= 1'b0;
        end else begin
            state <= state_nx;
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N; k++) bank[k] <= '0;
            acc   <= '0;
            aidx  <= '0;
            cnt   <= '0;
            min_q <= '0;
            idx_q <= '0;
        end else if (state == LOAD) begin
            for (int k = 0; k < N; k++) bank[k] <= bus.x[k*W +: W];
            acc  <= bus.x[W-1:0];
            aidx <= '0;
            cnt  <= (IW+1)'(1);
        end else if (state == SCAN) begin
            acc <= sel;
            if (lt) aidx <= cur;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                min_q <= sel;
                idx_q <= lt ? cur : aidx;
            end
        end
    end

    assign bus.soc     = armed && (state == START);
    assign bus.dav_    = (state != OUT);
    assign bus.busy    = (state != OUT) && (state != ACK);
    assign bus.min     = min_q;
    assign bus.min_idx = idx_q;

endmodule

// File: tb/tb_min_scan_scheduler.sv
// Scenario bench for min_scan_scheduler with an expected-result queue.
// Drives and samples on the falling edge.
module tb_min_scan_scheduler;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int IW = 2;

    typedef struct {
        logic [W-1:0]  m;
        logic [IW-1:0] i;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clock = ~clock;

    min_scan_scheduler_if #(.N(N), .W(W), .IW(IW)) bus ();

    min_scan_scheduler #(.N(N), .W(W), .IW(IW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [N*W-1:0] pk(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        return {c, b, a};
    endfunction

    function automatic exp_t model(input logic [N*W-1:0] xs);
        exp_t e;
        e.m = xs[W-1:0];
        e.i = '0;
        for (int k = 1; k < N; k++)
            if (xs[k*W +: W] < e.m) begin
                e.m = xs[k*W +: W];
                e.i = IW'(k);
            end
        return e;
    endfunction

    task automatic start_round(input logic [N*W-1:0] xs, output bit ok);
        ok = 1'b1;
        for (int c = 0; c < 20 && bus.soc !== 1'b1; c++) @(negedge clock);
        if (bus.soc !== 1'b1) ok = 1'b0;
        bus.eoc = '0;
        for (int c = 0; c < 20 && bus.soc !== 1'b0; c++) @(negedge clock);
        if (bus.soc !== 1'b0) ok = 1'b0;
        bus.x   = xs;
        bus.eoc = '1;
        sb.push_back(model(xs));
    endtask

    task automatic wait_dav(output int edges);
        edges = 0;
        do begin
            @(negedge clock);
            edges++;
            if (edges == 2) bus.x = (N*W)'($urandom);
        end while (bus.dav_ !== 1'b0 && edges < 40);
    endtask

    task automatic release_round();
        bus.rfd = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (bus.dav_ === 1'b1) break;
        end
        bus.rfd = 1'b1;
        @(negedge clock);
    endtask

    task automatic run_check(input string nm, input logic [N*W-1:0] xs);
        bit   ok;
        int   ed;
        exp_t e;
        start_round(xs, ok);
        wait_dav(ed);
        n_cmp++;
        if (!ok || bus.dav_ !== 1'b0) begin
            n_bad++;
            $display("FAIL %s handshake: ok=%0d dav_=%b want ok=1 dav_=0",
                     nm, ok, bus.dav_);
        end
        e = sb.pop_front();
        n_cmp++;
        if (bus.min !== e.m || bus.min_idx !== e.i) begin
            n_bad++;
            $display("FAIL %s result: got %h/%0d want %h/%0d",
                     nm, bus.min, bus.min_idx, e.m, e.i);
        end
        release_round();
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        bus.rfd = 1'b1;
        bus.eoc = '0;
        bus.x   = '0;
        repeat (2) @(negedge clock);
        n_cmp++;
        if (bus.soc !== 1'b0 || bus.dav_ !== 1'b1 || bus.min !== '0 ||
            bus.min_idx !== '0 || bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_vals: soc=%b dav_=%b min=%h idx=%0d busy=%b want 0 1 00 0 1",
                     bus.soc, bus.dav_, bus.min, bus.min_idx, bus.busy);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (bus.soc !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release_soc: got %b want 0", bus.soc);
        end
        @(negedge clock);
        n_cmp++;
        if (bus.soc !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_first_soc: got %b want 1", bus.soc);
        end
    endtask

    task automatic test_basic();
        bit   ok;
        int   ed;
        exp_t e;
        start_round(pk(8'h40, 8'h10, 8'h30), ok);
        wait_dav(ed);
        n_cmp++;
        if (!ok || ed != N + 1) begin
            n_bad++;
            $display("FAIL basic_latency: got %0d edges ok=%0d want %0d",
                     ed, ok, N + 1);
        end
        e = sb.pop_front();
        n_cmp++;
        if (bus.min !== e.m || bus.min_idx !== e.i ||
            e.m !== 8'h10 || e.i !== 2'd1) begin
            n_bad++;
            $display("FAIL basic_result: got %h/%0d want 10/1",
                     bus.min, bus.min_idx);
        end
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_busy: got %b want 0", bus.busy);
        end
        release_round();
    endtask

    task automatic test_tie();
        run_check("tie", pk(8'h22, 8'h22, 8'h22));
    endtask

    task automatic test_extremes();
        run_check("ext_low1", pk(8'hFF, 8'h00, 8'h00));
        run_check("ext_low0", pk(8'h00, 8'hFF, 8'hFF));
    endtask

    task automatic test_stall();
        bit   ok;
        bit   bad;
        int   ed;
        exp_t e;
        start_round(pk(8'h55, 8'h66, 8'h44), ok);
        wait_dav(ed);
        e   = sb.pop_front();
        bad = !ok;
        for (int c = 0; c < 10; c++) begin
            bus.eoc = N'($urandom);
            bus.x   = (N*W)'($urandom);
            @(negedge clock);
            if (bus.dav_ !== 1'b0 || bus.min !== e.m || bus.min_idx !== e.i)
                bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("FAIL stall_hold: dav_=%b min=%h/%0d want 0 %h/%0d",
                     bus.dav_, bus.min, bus.min_idx, e.m, e.i);
        end
        bus.rfd = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (bus.dav_ !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_drop: dav_=%b want 1", bus.dav_);
        end
        bad = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (bus.soc !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("FAIL stall_soc_early: soc=%b want 0", bus.soc);
        end
        bus.rfd = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (bus.soc !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_soc_again: soc=%b want 1", bus.soc);
        end
    endtask

    task automatic test_partial_eoc();
        bit   bad;
        int   ed;
        exp_t e;
        logic [N*W-1:0] xs;
        bad = 1'b0;
        bus.eoc = 3'b010;
        repeat (5) begin
            @(negedge clock);
            if (bus.soc !== 1'b1) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("FAIL partial_start: soc=%b want 1", bus.soc);
        end
        bus.eoc = '0;
        @(negedge clock);
        n_cmp++;
        if (bus.soc !== 1'b0) begin
            n_bad++;
            $display("FAIL partial_conv_soc: soc=%b want 0", bus.soc);
        end
        xs      = pk(8'h31, 8'h32, 8'h07);
        bus.x   = xs;
        bus.eoc = 3'b011;
        bad     = 1'b0;
        repeat (5) begin
            @(negedge clock);
            if (bus.dav_ !== 1'b1 || bus.busy !== 1'b1) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("FAIL partial_conv_wait: dav_=%b busy=%b want 1 1",
                     bus.dav_, bus.busy);
        end
        bus.eoc = '1;
        sb.push_back(model(xs));
        wait_dav(ed);
        e = sb.pop_front();
        n_cmp++;
        if (ed != N + 1 || bus.min !== e.m || bus.min_idx !== e.i) begin
            n_bad++;
            $display("FAIL partial_result: edges=%0d got %h/%0d want %0d %h/%0d",
                     ed, bus.min, bus.min_idx, N + 1, e.m, e.i);
        end
        release_round();
    endtask

    task automatic test_reset_mid_scan();
        bit ok;
        start_round(pk(8'h09, 8'h03, 8'h07), ok);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1;
        void'(sb.pop_back());
        n_cmp++;
        if (!ok || bus.soc !== 1'b0 || bus.dav_ !== 1'b1 ||
            bus.min !== '0 || bus.min_idx !== '0) begin
            n_bad++;
            $display("FAIL midscan_reset: soc=%b dav_=%b min=%h/%0d want 0 1 00/0",
                     bus.soc, bus.dav_, bus.min, bus.min_idx);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (bus.soc !== 1'b1) begin
            n_bad++;
            $display("FAIL midscan_restart: soc=%b want 1", bus.soc);
        end
        run_check("midscan_round", pk(8'h80, 8'h7F, 8'h81));
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 6; r++)
            run_check("b2b", pk(W'($urandom_range(0, 7)),
                                W'($urandom_range(0, 7)),
                                W'($urandom_range(0, 7))));
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_extremes();
        test_stall();
        test_partial_eoc();
        test_reset_mid_scan();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
